// File: rtl/dmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl_pkg
// Description : Shared widths, FSM state encodings and helpers for the
//               data-memory access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_ctrl_pkg;

  // Bus widths shared with the pipeline (RegBus-sized data, byte addresses)
  localparam int DMEM_DATA_W  = 32;
  localparam int DMEM_ADDR_W  = 32;

  // Default abort limit in REQ cycles and the width of the counter tracking it
  localparam int DMEM_TIMEOUT = 255;
  localparam int DMEM_CNT_W   = 8;

  // Controller states
  localparam logic [1:0] DMEM_IDLE = 2'd0;
  localparam logic [1:0] DMEM_REQ  = 2'd1;
  localparam logic [1:0] DMEM_DONE = 2'd2;

  // Word accesses only: both low address bits must be clear
  function automatic logic dmem_is_aligned(input logic [1:0] i_lsb);
    return (i_lsb == 2'b00);
  endfunction

endpackage : dmem_ctrl_pkg
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Data-memory access controller behind the MEM stage. Turns
//               each load/store into a req/ack bus transaction, stalls the
//               pipeline until it completes, rejects misaligned accesses and
//               aborts transactions that see no ack within TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int TIMEOUT = DMEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_MemRead,
  input  logic              mem_MemWrite,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              addr_err,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  // Counter value of the last REQ cycle allowed before the access is aborted
  localparam logic [DMEM_CNT_W-1:0] c_CNT_LAST = DMEM_CNT_W'(TIMEOUT - 1);
  localparam logic [DMEM_CNT_W-1:0] c_CNT_ONE  = DMEM_CNT_W'(1);

  logic [1:0]            r_state;
  logic [DMEM_CNT_W-1:0] r_cnt;

  logic w_access;
  logic w_aligned;
  logic w_start;

  assign w_access  = mem_MemRead | mem_MemWrite;
  assign w_aligned = dmem_is_aligned(dataAddr[1:0]);
  assign w_start   = (r_state == DMEM_IDLE) && w_access && w_aligned;

  // Freeze the pipeline from the cycle an aligned access is seen until DONE;
  // gated by reset so an access held on the inputs cannot raise it in reset
  always_comb begin
    stall = rst & (w_start | (r_state == DMEM_REQ));
  end

  // Access FSM: launch, wait for ack or timeout, then one DONE cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= DMEM_IDLE;
      r_cnt     <= '0;
      rdata     <= '0;
      addr_err  <= 1'b0;
      bus_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
      case (r_state)
        DMEM_IDLE: begin
          if (w_access) begin
            if (!w_aligned) begin
              addr_err <= 1'b1;
            end else begin
              // Write wins when both requests are raised together
              bus_we    <= mem_MemWrite;
              bus_addr  <= {dataAddr[ADDR_W-1:2], 2'b00};
              bus_wdata <= wdata;
              bus_req   <= 1'b1;
              r_cnt     <= '0;
              r_state   <= DMEM_REQ;
            end
          end
        end
        DMEM_REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
              rdata <= bus_rdata;
            end
            r_state <= DMEM_DONE;
          end else if (r_cnt == c_CNT_LAST) begin
            // Abandon the access; a load returns zero
            bus_req <= 1'b0;
            if (!bus_we) begin
              rdata <= '0;
            end
            bus_err <= 1'b1;
            r_state <= DMEM_DONE;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        DMEM_DONE: begin
          // Inputs here still belong to the finishing instruction
          r_state <= DMEM_IDLE;
        end
        default: begin
          r_state <= DMEM_IDLE;
        end
      endcase
    end
  end

endmodule : dmem_ctrl
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Self-checking bench for dmem_ctrl: directed vector table,
//               mid-transaction reset sequence and randomized transactions
//               compared against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [31:0] dataAddr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        addr_err;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_ctrl #(
    .DATA_W (32),
    .ADDR_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_MemRead (mem_MemRead),
    .mem_MemWrite(mem_MemWrite),
    .dataAddr    (dataAddr),
    .wdata       (wdata),
    .rdata       (rdata),
    .stall       (stall),
    .addr_err    (addr_err),
    .bus_err     (bus_err),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_ack     (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction: inputs, slave ack delay (0 = never), expectations
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    int          d;
    logic [31:0] rv;
    int          trail;
    int          e_stall;
    int          e_req;
    int          e_aerr;
    int          e_berr;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct {
    int          n_stall;
    int          n_req;
    int          n_aerr;
    int          n_berr;
    int          n_bad;
    logic [31:0] rd_done;
    bit          finished;
    bit          got_done;
  } res_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wd, input int d, input logic [31:0] rv,
                              input int trail, input int es, input int er, input int ea,
                              input int eb, input logic [31:0] erd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.d = d; v.rv = rv; v.trail = trail;
    v.e_stall = es; v.e_req = er; v.e_aerr = ea; v.e_berr = eb; v.e_rdata = erd;
    return v;
  endfunction

  // Transaction-level reference: outcome of one access given the slave delay
  function automatic void model(inout vec_t v, inout logic [31:0] m_rdata);
    if (v.addr[1:0] != 2'b00) begin
      v.e_stall = 0; v.e_req = 0; v.e_aerr = 1; v.e_berr = 0;
    end else if (v.d >= 1 && v.d <= TO) begin
      v.e_stall = v.d + 1; v.e_req = v.d; v.e_aerr = 0; v.e_berr = 0;
      if (!v.wr) m_rdata = v.rv;
    end else begin
      v.e_stall = TO + 1; v.e_req = TO; v.e_aerr = 0; v.e_berr = 1;
      if (!v.wr) m_rdata = 32'h0;
    end
    v.e_rdata = m_rdata;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drive one access as the MEM stage would, acting as bus slave meanwhile
  task automatic run_txn(input vec_t v, output res_t r);
    bit active;
    bit seen_stall;
    int left;
    active = 1'b1; seen_stall = 1'b0; left = 0;
    r.n_stall = 0; r.n_req = 0; r.n_aerr = 0; r.n_berr = 0; r.n_bad = 0;
    r.rd_done = 32'h0; r.finished = 1'b0; r.got_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (active) begin
        mem_MemRead = v.rd; mem_MemWrite = v.wr; dataAddr = v.addr; wdata = v.wd;
      end else begin
        mem_MemRead = 1'b0; mem_MemWrite = 1'b0; dataAddr = $urandom; wdata = $urandom;
      end
      #1;
      if (stall)    r.n_stall++;
      if (addr_err) r.n_aerr++;
      if (bus_err)  r.n_berr++;
      if (bus_req) begin
        r.n_req++;
        if (bus_addr != {v.addr[31:2], 2'b00} || bus_we != v.wr ||
            (v.wr && bus_wdata != v.wd)) r.n_bad++;
        bus_ack   = (r.n_req == v.d);
        bus_rdata = bus_ack ? v.rv : $urandom;
      end else if (!active) begin
        bus_ack = 1'b1; bus_rdata = $urandom;   // stray ack while idle
      end else begin
        bus_ack = 1'b0; bus_rdata = $urandom;
      end
      if (active) begin
        if (stall) begin
          seen_stall = 1'b1;
        end else if (seen_stall || c == 0) begin
          r.got_done = seen_stall; r.rd_done = rdata; r.finished = 1'b1;
          active = 1'b0; left = v.trail;
          if (left == 0) break;
        end
      end else begin
        left--;
        if (left == 0) break;
      end
    end
  endtask

  task automatic check_txn(input string tag, input vec_t v, input res_t r);
    chk({tag, ".finished"}, 32'(r.finished), 32'd1);
    chk({tag, ".stall_cycles"}, r.n_stall, v.e_stall);
    chk({tag, ".req_cycles"}, r.n_req, v.e_req);
    chk({tag, ".addr_err"}, r.n_aerr, v.e_aerr);
    chk({tag, ".bus_err"}, r.n_berr, v.e_berr);
    chk({tag, ".bus_fields_bad"}, r.n_bad, 0);
    chk({tag, ".rdata"}, rdata, v.e_rdata);
    if (v.addr[1:0] == 2'b00) begin
      chk({tag, ".done_seen"}, 32'(r.got_done), 32'd1);
      chk({tag, ".rdata_done"}, r.rd_done, v.e_rdata);
    end
  endtask

  vec_t vt[10];
  vec_t v;
  res_t r;
  logic [31:0] m_rdata;

  initial begin
    // Directed vectors, expectations derived by hand (TIMEOUT = 4, rdata from 0)
    vt[0] = mk(1, 0, 32'h10, 32'h0,         3, 32'h1234_5678, 1, 4, 3, 0, 0, 32'h1234_5678);
    vt[1] = mk(0, 1, 32'h20, 32'hCAFE_F00D, 1, 32'h5555_AAAA, 1, 2, 1, 0, 0, 32'h1234_5678);
    vt[2] = mk(1, 0, 32'h13, 32'h0,         1, 32'h0,         2, 0, 0, 1, 0, 32'h1234_5678);
    vt[3] = mk(1, 0, 32'h40, 32'h0,         0, 32'h0,         1, 5, 4, 0, 1, 32'h0);
    vt[4] = mk(1, 1, 32'h44, 32'hA5A5_A5A5, 2, 32'hDEAD_BEEF, 1, 3, 2, 0, 0, 32'h0);
    vt[5] = mk(1, 0, 32'h50, 32'h0,         1, 32'h1111_2222, 0, 2, 1, 0, 0, 32'h1111_2222);
    vt[6] = mk(1, 0, 32'h54, 32'h0,         2, 32'h3333_4444, 1, 3, 2, 0, 0, 32'h3333_4444);
    vt[7] = mk(0, 1, 32'h62, 32'h7777_7777, 1, 32'h0,         2, 0, 0, 1, 0, 32'h3333_4444);
    vt[8] = mk(1, 0, 32'h7C, 32'h0,         4, 32'h0F0F_0F0F, 1, 5, 4, 0, 0, 32'h0F0F_0F0F);
    vt[9] = mk(0, 1, 32'h80, 32'h1357_9BDF, 0, 32'h0,         1, 5, 4, 0, 1, 32'h0F0F_0F0F);

    rst = 1'b0; mem_MemRead = 1'b0; mem_MemWrite = 1'b0;
    dataAddr = 32'h0; wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("reset.stall", 32'(stall), 32'd0);
    chk("reset.bus_req", 32'(bus_req), 32'd0);
    chk("reset.bus_we", 32'(bus_we), 32'd0);
    chk("reset.addr_err", 32'(addr_err), 32'd0);
    chk("reset.bus_err", 32'(bus_err), 32'd0);
    chk("reset.rdata", rdata, 32'h0);
    chk("reset.bus_addr", bus_addr, 32'h0);
    chk("reset.bus_wdata", bus_wdata, 32'h0);
    #1 rst = 1'b1;

    // Directed table (vt[5] ends in DONE, so vt[6] starts in the next cycle)
    for (int i = 0; i < 10; i++) begin
      run_txn(vt[i], r);
      check_txn($sformatf("vec%0d", i), vt[i], r);
    end

    // Reset asserted in the middle of REQ, access still held
    @(negedge clk);
    bus_ack = 1'b0; mem_MemRead = 1'b1; mem_MemWrite = 1'b0; dataAddr = 32'h90;
    @(negedge clk); @(negedge clk); #1;
    chk("midrst.pre_req", 32'(bus_req), 32'd1);
    chk("midrst.pre_stall", 32'(stall), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst.req_drop", 32'(bus_req), 32'd0);
    chk("midrst.stall_drop", 32'(stall), 32'd0);
    chk("midrst.rdata_clr", rdata, 32'h0);
    mem_MemRead = 1'b0;
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    #1;
    chk("midrst.idle_stall", 32'(stall), 32'd0);
    chk("midrst.idle_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("midrst.late_ack_rdata", rdata, 32'h0);
    chk("midrst.late_ack_req", 32'(bus_req), 32'd0);
    chk("midrst.late_ack_stall", 32'(stall), 32'd0);

    // Randomized transactions against the reference model
    m_rdata = 32'h0;
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(1, 3);
      v.rd = k[0]; v.wr = k[1];
      v.addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) v.addr[1:0] = 2'($urandom_range(1, 3));
      v.wd = $urandom; v.rv = $urandom;
      v.d = $urandom_range(0, TO + 1);
      v.trail = $urandom_range(1, 2);
      model(v, m_rdata);
      run_txn(v, r);
      check_txn($sformatf("rnd%0d", i), v, r);
    end

    @(negedge clk);
    bus_ack = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dmem_ctrl
`default_nettype wire

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory access controller sitting directly downstream of the MEM stage.
- Consumes the MEM stage's mem_MemRead, mem_MemWrite, dataAddr and wdata, and returns rdata to MEM.
- Converts each access into a req/ack transaction on a variable-latency data bus.
- Freezes the pipeline through stall until the access completes, with alignment checking and a bus timeout.

Parameters:
- DATA_W, 32, data word width (matches `RegBus).
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, maximum REQ cycles without bus_ack before the access is aborted; range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- mem_MemRead  in  1  read request from MEM stage.
- mem_MemWrite  in  1  write request from MEM stage.
- dataAddr  in  ADDR_W  byte address from MEM stage.
- wdata  in  DATA_W  store data from MEM stage.
- rdata  out  DATA_W  load data returned to MEM stage.
- stall  out  1  freeze PC and all pipeline registers while 1.
- addr_err  out  1  one-cycle pulse: misaligned access rejected.
- bus_err  out  1  one-cycle pulse: access aborted on timeout.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  ADDR_W  word-aligned bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_rdata  in  DATA_W  bus read data, valid when bus_ack = 1.
- bus_ack  in  1  transaction complete; single-cycle pulse.

Behaviour:
- Reset values: state=IDLE; rdata, bus_addr, bus_wdata, timeout counter = 0; bus_req, bus_we, stall, addr_err, bus_err = 0. Reset takes effect immediately. A reset mid-transaction drops bus_req at once; the bus slave must tolerate an abandoned request.
- access = mem_MemRead | mem_MemWrite. Write has priority if both are 1; the cycle is then treated as a write.
- States: IDLE, REQ, DONE.
- IDLE, access, dataAddr[1:0] != 0:
  - addr_err pulses (registered, so it is 1 in the following cycle).
  - No bus transaction; stall = 0; stay in IDLE.
  - rdata is unchanged.
- IDLE, access, aligned:
  - stall = 1 combinationally in this same cycle.
  - Latch bus_addr, bus_wdata and bus_we; bus_req <= 1; counter <= 0; go to REQ.
- REQ:
  - stall = 1; bus_req, bus_addr, bus_we and bus_wdata are held stable.
  - On bus_ack: bus_req <= 0; a read latches rdata <= bus_rdata; go to DONE.
  - Without bus_ack: counter increments. When counter == TIMEOUT-1 with no ack: bus_req <= 0; rdata <= 0 for reads; bus_err pulses; go to DONE.
- DONE:
  - stall = 0 and rdata is valid; the pipeline advances at the end of this cycle; go to IDLE.
  - An access presented in DONE belongs to the same instruction and is ignored.
- Minimum latency: ack in the first REQ cycle gives 2 stall cycles (the IDLE-detect cycle and REQ). The access completes in DONE.
- bus_ack outside REQ is ignored.
- rdata holds its last value across writes and across idle cycles.
- stall is the only combinational output; it depends only on state, access and dataAddr[1:0].

Decomposition:
- Shared package (defines header alongside `RegBus/`InstAddrBus): state encodings DMEM_IDLE/REQ/DONE (2 bits); the DMEM_TIMEOUT default.
- No sub-module. The timeout counter is inline; the block is a single FSM.

Test Plan:
- Aligned read to 0x0000_0010, bus_ack in the 3rd REQ cycle with bus_rdata=0x1234_5678 -> stall high 4 cycles, bus_req high 3 cycles with bus_addr=0x10 and bus_we=0, rdata=0x1234_5678 in DONE with stall=0.
- Write to 0x0000_0020 with wdata=0xCAFE_F00D, ack in the first REQ cycle -> bus_we=1, bus_wdata=0xCAFE_F00D, stall high exactly 2 cycles, rdata unchanged.
- Read to 0x0000_0013 -> addr_err pulses once, bus_req never asserts, stall stays 0.
- Read with no bus_ack, TIMEOUT=4 -> bus_req high 4 cycles, then drops; bus_err pulses once; rdata=0; stall releases in DONE.
- mem_MemRead=mem_MemWrite=1 -> bus_we=1 (write priority). Back-to-back reads on consecutive instructions -> the second access starts only in the IDLE cycle after DONE.
- rst driven low during REQ -> bus_req and stall fall immediately, without waiting for a clock edge; after release the state is IDLE and a later ack is ignored.
